// File: rtl/rand_history_reader_if.sv
// Bus between the random-result source / key front end and the history reader.
// The master side produces results and key levels and observes the display.
// The slave side is the reader itself.
interface rand_history_reader_if #(
    parameter int DATA_W = 4,
    parameter int PTR_W  = 2
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_prev;
    logic              i_next;
    logic [DATA_W-1:0] o_data;
    logic [PTR_W-1:0]  o_index;
    logic [PTR_W:0]    o_count;
    logic              o_browsing;

    modport master (
        output i_valid, i_data, i_prev, i_next,
        input  o_data, o_index, o_count, o_browsing
    );

    modport slave (
        input  i_valid, i_data, i_prev, i_next,
        output o_data, o_index, o_count, o_browsing
    );
endinterface

// File: rtl/rand_history_reader.sv
// Circular history of finalized random results with prev/next browsing.
// A new result or an idle timeout snaps the display back to the newest entry.
module rand_history_reader #(
    parameter int          DATA_W      = 4,
    parameter int          DEPTH       = 4,
    parameter int          PTR_W       = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rand_history_reader_if.slave  bus
);
    localparam int               CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [31:0]      TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;

    typedef enum logic {
        S_LIVE,
        S_BROWSE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  offset_q, offset_d;
    logic [31:0]       timer_q, timer_d;
    logic              prev_key_q, prev_key_d;
    logic              next_key_q, next_key_d;

    logic              prev_press;
    logic              next_press;
    logic [CNT_W-1:0]  offset_up;
    logic [PTR_W-1:0]  rd_ptr;

    // A held key produces one press: only the rising edge against last cycle's level counts.
    assign prev_press = bus.i_prev & ~prev_key_q;
    assign next_press = bus.i_next & ~next_key_q;
    assign offset_up  = {1'b0, offset_q} + CNT_W'(1);

    // State register: every flop, cleared together by the synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_LIVE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            offset_q   <= '0;
            timer_q    <= '0;
            prev_key_q <= 1'b0;
            next_key_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            offset_q   <= offset_d;
            timer_q    <= timer_d;
            prev_key_q <= prev_key_d;
            next_key_q <= next_key_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next state: a new result beats any key, a double press only restarts the timer.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        offset_d   = offset_q;
        timer_d    = timer_q;
        prev_key_d = bus.i_prev;
        next_key_d = bus.i_next;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (bus.i_valid) begin
            mem_d[wr_ptr_q] = bus.i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            count_d         = (count_q == DEPTH_C) ? count_q : count_q + CNT_W'(1);
            offset_d        = '0;
            state_d         = S_LIVE;
            timer_d         = '0;
        end else if (prev_press && next_press) begin
            timer_d = '0;
        end else begin
            case (state_q)
                S_LIVE: begin
                    timer_d = '0;
                    if (prev_press && count_q >= CNT_W'(2)) begin
                        offset_d = PTR_W'(1);
                        state_d  = S_BROWSE;
                    end
                end
                S_BROWSE: begin
                    if (prev_press) begin
                        timer_d = '0;
                        if (offset_up < count_q) begin
                            offset_d = offset_q + PTR_W'(1);
                        end
                    end else if (next_press) begin
                        timer_d  = '0;
                        offset_d = offset_q - PTR_W'(1);
                        if (offset_q == PTR_W'(1)) begin
                            state_d = S_LIVE;
                        end
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d  = '0;
                        offset_d = '0;
                        state_d  = S_LIVE;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: begin
                    state_d  = S_LIVE;
                    offset_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    // Outputs: the displayed entry counts back from the newest write; empty history shows 0.
    always_comb begin
        rd_ptr         = wr_ptr_q - PTR_W'(1) - offset_q;
        bus.o_data     = (count_q == '0) ? '0 : mem_q[rd_ptr];
        bus.o_index    = offset_q;
        bus.o_count    = count_q;
        bus.o_browsing = (state_q == S_BROWSE);
    end
endmodule

// File: tb/tb_rand_history_reader.sv
// Testbench for rand_history_reader: scripted vectors, hand-written corner sequences
// and a randomized run compared against a queue-based history model.
module tb_rand_history_reader;
    localparam int          DATA_W  = 4;
    localparam int          DEPTH   = 4;
    localparam int          PTR_W   = 2;
    localparam logic [31:0] TIMEOUT = 32'd16;

    logic i_clk;
    logic i_rst_n;

    int n_cmp;
    int n_fail;

    rand_history_reader_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    rand_history_reader #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // Free-running clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference model: history as a queue with the newest result at the front,
    // timeout measured as edges elapsed since the last browse activity.
    logic [DATA_W-1:0] hist[$];
    int                m_offset;
    bit                m_browsing;
    int                m_cycle;
    int                m_last_touch;
    bit                m_prev_l;
    bit                m_next_l;

    function automatic void modelStep(bit rst_n, bit valid, logic [DATA_W-1:0] data,
                                      bit prev, bit next);
        bit pp;
        bit np;
        m_cycle++;
        if (!rst_n) begin
            hist.delete();
            m_offset   = 0;
            m_browsing = 0;
            m_prev_l   = 0;
            m_next_l   = 0;
            return;
        end
        pp       = prev && !m_prev_l;
        np       = next && !m_next_l;
        m_prev_l = prev;
        m_next_l = next;
        if (valid) begin
            hist.push_front(data);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            m_offset   = 0;
            m_browsing = 0;
        end else if (pp && np) begin
            m_last_touch = m_cycle;
        end else if (pp) begin
            if (!m_browsing) begin
                if (hist.size() >= 2) begin
                    m_offset     = 1;
                    m_browsing   = 1;
                    m_last_touch = m_cycle;
                end
            end else begin
                if (m_offset + 1 < hist.size()) m_offset++;
                m_last_touch = m_cycle;
            end
        end else if (np) begin
            if (m_browsing) begin
                m_offset--;
                m_last_touch = m_cycle;
                if (m_offset == 0) m_browsing = 0;
            end
        end else if (m_browsing && (m_cycle - m_last_touch == int'(TIMEOUT))) begin
            m_offset   = 0;
            m_browsing = 0;
        end
    endfunction

    // One clock cycle: drive inputs, let the edge happen, advance the model in step.
    task automatic applyStimulus(input bit rst_n, input bit valid, input logic [DATA_W-1:0] data,
                                 input bit prev, input bit next);
        i_rst_n     = rst_n;
        bus.i_valid = valid;
        bus.i_data  = data;
        bus.i_prev  = prev;
        bus.i_next  = next;
        @(posedge i_clk);
        modelStep(rst_n, valid, data, prev, next);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] e_data,
                               input logic [PTR_W-1:0] e_idx, input logic [PTR_W:0] e_cnt,
                               input logic e_br);
        n_cmp += 4;
        if (bus.o_data !== e_data) begin
            n_fail++;
            $display("[TB] FAIL %s o_data: got %0d expected %0d", name, bus.o_data, e_data);
        end
        if (bus.o_index !== e_idx) begin
            n_fail++;
            $display("[TB] FAIL %s o_index: got %0d expected %0d", name, bus.o_index, e_idx);
        end
        if (bus.o_count !== e_cnt) begin
            n_fail++;
            $display("[TB] FAIL %s o_count: got %0d expected %0d", name, bus.o_count, e_cnt);
        end
        if (bus.o_browsing !== e_br) begin
            n_fail++;
            $display("[TB] FAIL %s o_browsing: got %0d expected %0d", name, bus.o_browsing, e_br);
        end
    endtask

    task automatic checkModel(input string name);
        logic [DATA_W-1:0] d;
        d = (hist.size() == 0) ? '0 : hist[m_offset];
        checkOutput(name, d, PTR_W'(m_offset), (PTR_W + 1)'(hist.size()), m_browsing);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic write(input logic [DATA_W-1:0] d);
        applyStimulus(1, 1, d, 0, 0);
    endtask

    // Press and release a key, two cycles.
    task automatic pressPrev();
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              prev;
        logic              next;
        logic [DATA_W-1:0] e_data;
        logic [PTR_W-1:0]  e_idx;
        logic [PTR_W:0]    e_cnt;
        logic              e_br;
    } vec_t;

    vec_t vecs[13];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_cycle      = 0;
        m_last_touch = 0;
        i_rst_n      = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_prev   = 1'b0;
        bus.i_next   = 1'b0;

        vecs[0]  = '{1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  2'd0, 3'd1, 1'b0};
        vecs[1]  = '{1'b1, 4'd7,  1'b0, 1'b0, 4'd7,  2'd0, 3'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'd12, 1'b0, 1'b0, 4'd12, 2'd0, 3'd3, 1'b0};
        vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  2'd1, 3'd3, 1'b1};
        vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd7,  2'd1, 3'd3, 1'b1};
        vecs[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  2'd2, 3'd3, 1'b1};
        vecs[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd3,  2'd2, 3'd3, 1'b1};
        vecs[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  2'd2, 3'd3, 1'b1};
        vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd3,  2'd2, 3'd3, 1'b1};
        vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd7,  2'd1, 3'd3, 1'b1};
        vecs[10] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd7,  2'd1, 3'd3, 1'b1};
        vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd12, 2'd0, 3'd3, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd12, 2'd0, 3'd3, 1'b0};

        // Reset, idle, and keys on an empty history.
        doReset();
        checkOutput("reset", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("idle", 0, 0, 0, 0);
        pressPrev();
        checkOutput("empty_prev", 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("empty_next", 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        // Scripted browse over three results.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, vecs[i].valid, vecs[i].data, vecs[i].prev, vecs[i].next);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_idx,
                        vecs[i].e_cnt, vecs[i].e_br);
        end

        // Wraparound: six writes keep only the last four.
        doReset();
        for (int i = 1; i <= 6; i++) write(4'(i));
        checkOutput("wrap_live", 6, 0, 4, 1'b0);
        pressPrev();
        checkOutput("wrap_p1", 5, 1, 4, 1'b1);
        pressPrev();
        checkOutput("wrap_p2", 4, 2, 4, 1'b1);
        pressPrev();
        checkOutput("wrap_p3", 3, 3, 4, 1'b1);
        pressPrev();
        checkOutput("wrap_hold", 3, 3, 4, 1'b1);

        // New result in the same cycle as a prev press wins and the press is lost.
        doReset();
        write(1); write(2); write(3);
        pressPrev();
        pressPrev();
        checkOutput("pre_valid", 1, 2, 3, 1'b1);
        applyStimulus(1, 1, 9, 1, 0);
        checkOutput("valid_vs_prev", 9, 0, 4, 1'b0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("held_after_valid", 9, 0, 4, 1'b0);
        applyStimulus(1, 0, 0, 0, 0);

        // Idle timeout and restart of the count by a press.
        doReset();
        write(5); write(8);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("to_press", 5, 1, 2, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("to_k%0d", k), (k < 16) ? 4'd5 : 4'd8,
                        (k < 16) ? 2'd1 : 2'd0, 3'd2, k < 16);
        end
        applyStimulus(1, 0, 0, 1, 0);
        for (int k = 1; k <= 26; k++) begin
            applyStimulus(1, 0, 0, (k == 10), 0);
            checkOutput($sformatf("to2_k%0d", k), (k < 26) ? 4'd5 : 4'd8,
                        (k < 26) ? 2'd1 : 2'd0, 3'd2, k < 26);
        end

        // Held key steps once; simultaneous rising keys do nothing.
        doReset();
        write(1); write(2); write(3);
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1, 0, 0, 1, 0);
            if (k == 2) checkOutput("held_one_step", 2, 1, 3, 1'b1);
            checkModel("held_model");
        end
        applyStimulus(1, 0, 0, 0, 0);
        pressPrev();
        checkOutput("before_both", 2, 1, 3, 1'b1);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("both_keys", 2, 1, 3, 1'b1);
        applyStimulus(1, 0, 0, 0, 0);
        pressPrev();
        checkOutput("browse_idx2", 1, 2, 3, 1'b1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset_browse", 0, 0, 0, 0);

        // Randomized run against the model, alternating busy and quiet phases.
        applyStimulus(1, 0, 0, 0, 0);
        for (int c = 0; c < 1200; c++) begin
            int key_div;
            bit rst_n;
            key_div = ((c / 100) % 2 == 0) ? 3 : 40;
            rst_n   = ($urandom_range(0, 299) != 0);
            applyStimulus(rst_n, $urandom_range(0, 9) == 0, 4'($urandom),
                          $urandom_range(0, key_div) == 0, $urandom_range(0, key_div) == 0);
            checkModel($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
